timer_counter: RTL

Memory-mapped countdown timer that generates the external `interrupt` input of the `mips` core. It sits on the data-side system bridge alongside data memory: the core writes and reads its three registers with `sw`/`lw`, and its `irq` output drives the CPU interrupt pin directly or through the bridge. It supports one-shot and auto-reload modes, with a per-timer interrupt mask.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_counter.sv | 106 ++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared FSM states, register offsets and CTRL field layout for timer_counter
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with irq; TIMER_AUTORELOAD_EN enables auto-reload mode
module timer_counter
    import timer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    timer_state_e state;
    logic         ctrl_en;
    logic [1:0]   ctrl_mode;
    logic         ctrl_im;
    logic [31:0]  preset;
    logic [31:0]  count;
    logic         irq_r;
    logic         auto_reload;
    logic         ctrl_wr;
    logic         preset_wr;
    logic         unused_addr;

    assign ctrl_wr     = we && (addr[3:2] == REG_CTRL);
    assign preset_wr   = we && (addr[3:2] == REG_PRESET);
    assign unused_addr = ^{addr[ADDR_W-1:4], addr[1:0]};

`ifdef TIMER_AUTORELOAD_EN
    assign auto_reload = (ctrl_mode == MODE_RELOAD);
`else
    assign auto_reload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            irq_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        state <= ST_INT;
                        irq_r <= 1'b1;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        irq_r <= 1'b0;
                        state <= ST_LOAD;
                    end else begin
                        ctrl_en <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Bus writes come last so they override any FSM update made this cycle.
            if (ctrl_wr) begin
                ctrl_en   <= wdata[CTRL_EN_BIT];
                ctrl_mode <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                ctrl_im   <= wdata[CTRL_IM_BIT];
                irq_r     <= 1'b0;
            end
            if (preset_wr) begin
                preset <= wdata;
                irq_r  <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            REG_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

    assign irq = irq_r & ctrl_im;

endmodule
